// File: rtl/fix_to_single_pipe_pkg.sv
// rtl/fix_to_single_pipe_pkg.sv - IEEE single constants, field struct and packing helper
package fix_float_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } ieee_single_t;

  function automatic logic [31:0] pack_single(input logic sign, input logic [EXP_W-1:0] exp,
                                              input logic [MANT_W-1:0] mant);
    ieee_single_t s;
    s.sign = sign;
    s.exp  = exp;
    s.mant = mant;
    return s;
  endfunction

endpackage

// File: rtl/fix_to_single_pipe_if.sv
// rtl/fix_to_single_pipe_if.sv - valid/ready input and output bus of the fixed-to-single converter
interface fix_to_single_pipe_if #(parameter int W = 16);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_fixed;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_single;

  modport master (output in_valid, in_fixed, out_ready,
                  input  in_ready, out_valid, out_single);

  modport slave  (input  in_valid, in_fixed, out_ready,
                  output in_ready, out_valid, out_single);

endinterface

// File: rtl/fix_to_single_pipe_lzc.sv
// rtl/fix_to_single_pipe_lzc.sv - combinational leading-zero counter; all-zero input counts WIDTH
module lzc #(
  parameter int WIDTH = 16,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in,
  output logic [CW-1:0]    cnt
);

  // Scan upward so the highest set bit makes the last assignment.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fix_to_single_pipe.sv
// rtl/fix_to_single_pipe.sv - three-stage signed fixed-point to IEEE single converter
// Stages: sign/magnitude, normalise, round-to-nearest-even and pack.
module fix_to_single_pipe
  import fix_float_pkg::*;
#(
  parameter int INT_WIDTH   = 12,
  parameter int FRACT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fix_to_single_pipe_if.slave  bus
);

  localparam int W   = INT_WIDTH + FRACT_WIDTH;
  localparam int LZW = $clog2(W + 1);
  localparam int XW  = 55;

  if (W < 2 || W > 32) begin : g_width_check
    $error("fix_to_single_pipe: INT_WIDTH+FRACT_WIDTH must be 2..32");
  end

  logic           v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic           sign1_q, sign1_d, zero1_q, zero1_d;
  logic [W-1:0]   mag1_q, mag1_d;
  logic           sign2_q, sign2_d, zero2_q, zero2_d;
  logic [W-1:0]   norm2_q, norm2_d;
  logic [7:0]     exp2_q, exp2_d;
  logic [31:0]    out_q, out_d;

  logic           adv1, adv2, adv3;
  logic [LZW-1:0] lz;
  logic [XW-1:0]  frac_ext;
  logic           guard, sticky, round_up;
  logic [23:0]    mant_r;
  logic [7:0]     exp_r;

  lzc #(.WIDTH(W)) u_lzc (.in(mag1_q), .cnt(lz));

  always_comb begin
    adv3 = !v3_q || bus.out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;

    v1_d = v1_q; sign1_d = sign1_q; zero1_d = zero1_q; mag1_d = mag1_q;
    v2_d = v2_q; sign2_d = sign2_q; zero2_d = zero2_q; norm2_d = norm2_q; exp2_d = exp2_q;
    v3_d = v3_q; out_d = out_q;

    if (adv1) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        sign1_d = bus.in_fixed[W-1];
        mag1_d  = sign1_d ? (W'(0) - bus.in_fixed) : bus.in_fixed;
        zero1_d = (mag1_d == '0);
      end
    end

    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        sign2_d = sign1_q;
        zero2_d = zero1_q;
        norm2_d = mag1_q << lz;
        exp2_d  = 8'(W - 1 - int'(lz) - FRACT_WIDTH + EXP_BIAS);
      end
    end

    // Bits below the hidden one, left-aligned: mantissa, then guard, then sticky.
    frac_ext = XW'(norm2_q[W-2:0]) << (XW - (W - 1));
    guard    = frac_ext[XW-1-MANT_W];
    sticky   = |frac_ext[XW-2-MANT_W:0];
    round_up = guard && (sticky || frac_ext[XW-MANT_W]);
    mant_r   = {1'b0, frac_ext[XW-1 -: MANT_W]} + 24'(round_up);
    exp_r    = exp2_q + 8'(mant_r[23]);

    if (adv3) begin
      v3_d = v2_q;
      if (v2_q) out_d = zero2_q ? 32'h0 : pack_single(sign2_q, exp_r, mant_r[22:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      sign1_q <= 1'b0; zero1_q <= 1'b0; mag1_q <= '0;
      sign2_q <= 1'b0; zero2_q <= 1'b0; norm2_q <= '0; exp2_q <= '0;
      out_q <= 32'h0;
    end else begin
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
      sign1_q <= sign1_d; zero1_q <= zero1_d; mag1_q <= mag1_d;
      sign2_q <= sign2_d; zero2_q <= zero2_d; norm2_q <= norm2_d; exp2_q <= exp2_d;
      out_q <= out_d;
    end
  end

  assign bus.in_ready   = adv1;
  assign bus.out_valid  = v3_q;
  assign bus.out_single = out_q;

endmodule

// File: tb/tb_fix_to_single_pipe.sv
// tb/tb_fix_to_single_pipe.sv - self-checking bench for the 12.4 and 16.16 converters
module tb_fix_to_single_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fix_to_single_pipe_if #(.W(16)) ia ();
  fix_to_single_pipe_if #(.W(32)) ib ();

  fix_to_single_pipe #(.INT_WIDTH(12), .FRACT_WIDTH(4))  dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  fix_to_single_pipe #(.INT_WIDTH(16), .FRACT_WIDTH(16)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  int errors = 0;
  int checks = 0;
  int outs_a = 0;
  logic [31:0] exp_a[$], exp_b[$], got_a[$];
  logic        hold_a = 1'b0, hold_b = 1'b0;
  logic [31:0] prev_a, prev_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: exact double of the fixed value, then round-to-nearest-even to single.
  function automatic logic [31:0] ref_single(input longint v, input int f);
    logic [63:0] b;
    logic [23:0] m;
    int          e;
    if (v == 0) return 32'h0;
    b = $realtobits(real'(v) / (2.0 ** f));
    e = int'(b[62:52]) - 1023 + 127;
    m = {1'b0, b[51:29]};
    if (b[28] && ((|b[27:0]) || b[29])) m = m + 24'd1;
    if (m[23]) begin
      e = e + 1;
      m = '0;
    end
    return {b[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] r;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r = 32'h0;
      1: r = 32'd1 << (w - 1);
      2: r = (32'd1 << (w - 1)) - 32'd1;
      3: r = 32'hFFFF_FFFF;
      4: r[7:0] = 8'h80;
      default: ;
    endcase
    return r & mask;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_a.delete();
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        check("a_stall_valid", 32'(ia.out_valid), 32'd1);
        check("a_stall_data", ia.out_single, prev_a);
      end
      if (ia.out_valid && ia.out_ready) begin
        if (exp_a.size() == 0) check("a_spurious_out", 32'(ia.out_valid), 32'd0);
        else begin
          check("a_data", ia.out_single, exp_a.pop_front());
          got_a.push_back(ia.out_single);
          outs_a++;
        end
      end
      if (ia.in_valid && ia.in_ready) exp_a.push_back(ref_single(longint'($signed(ia.in_fixed)), 4));
      hold_a = ia.out_valid && !ia.out_ready;
      prev_a = ia.out_single;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_b.delete();
      hold_b = 1'b0;
    end else begin
      if (hold_b) begin
        check("b_stall_valid", 32'(ib.out_valid), 32'd1);
        check("b_stall_data", ib.out_single, prev_b);
      end
      if (ib.out_valid && ib.out_ready) begin
        if (exp_b.size() == 0) check("b_spurious_out", 32'(ib.out_valid), 32'd0);
        else check("b_data", ib.out_single, exp_b.pop_front());
      end
      if (ib.in_valid && ib.in_ready) exp_b.push_back(ref_single(longint'($signed(ib.in_fixed)), 16));
      hold_b = ib.out_valid && !ib.out_ready;
      prev_b = ib.out_single;
    end
  end

  task automatic dir_a(input logic [15:0] v, input logic [31:0] want, input string name);
    int n;
    @(posedge clk); #1;
    ia.in_valid = 1'b1; ia.in_fixed = v;
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    n = 1;
    while (!ia.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd3);
    check(name, ia.out_single, want);
  endtask

  task automatic dir_b(input logic [31:0] v, input logic [31:0] want, input string name);
    int n;
    @(posedge clk); #1;
    ib.in_valid = 1'b1; ib.in_fixed = v;
    @(posedge clk); #1;
    ib.in_valid = 1'b0;
    n = 1;
    while (!ib.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd3);
    check(name, ib.out_single, want);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] bp_vals[4];
    logic [31:0] bp_want[4];
    int          k;
    int          base;
    bp_vals = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
    bp_want = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

    ia.in_valid = 1'b0; ia.in_fixed = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_fixed = '0; ib.out_ready = 1'b1;

    check("model_1p0",      ref_single(16, 4),            32'h3F80_0000);
    check("model_m2048",    ref_single(-32768, 4),        32'hC500_0000);
    check("model_tie_up",   ref_single(64'h0100_0003, 16), 32'h4380_0002);
    check("model_carry",    ref_single(64'h01FF_FFFF, 16), 32'h4400_0000);

    repeat (3) @(posedge clk);
    #1;
    check("rst_a_out_valid",  32'(ia.out_valid), 32'd0);
    check("rst_a_out_single", ia.out_single,     32'h0);
    check("rst_b_out_valid",  32'(ib.out_valid), 32'd0);
    check("rst_b_out_single", ib.out_single,     32'h0);
    rst = 1'b0;
    #1;
    check("rst_a_in_ready", 32'(ia.in_ready), 32'd1);

    dir_a(16'h0010, 32'h3F80_0000, "a_one");
    dir_a(16'hFFF0, 32'hBF80_0000, "a_minus_one");
    dir_a(16'h0008, 32'h3F00_0000, "a_half");
    dir_a(16'h0000, 32'h0000_0000, "a_zero");
    dir_a(16'h8000, 32'hC500_0000, "a_most_neg");
    dir_a(16'h7FFF, 32'h44FF_FE00, "a_max");
    dir_b(32'h0100_0001, 32'h4380_0000, "b_tie_down");
    dir_b(32'h0100_0003, 32'h4380_0002, "b_tie_up");
    dir_b(32'h01FF_FFFF, 32'h4400_0000, "b_carry");
    dir_b(32'h8000_0000, 32'hC700_0000, "b_most_neg");

    // Backpressure: four samples, consumer stalls for cycles 4..7.
    repeat (3) @(posedge clk);
    got_a.delete();
    k = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      ia.in_valid  = (k < 4);
      ia.in_fixed  = bp_vals[k % 4];
      ia.out_ready = !(c >= 4 && c <= 7);
      @(negedge clk);
      if (c == 6) check("bp_in_ready_full", 32'(ia.in_ready), 32'd0);
      if (ia.in_valid && ia.in_ready) k++;
    end
    ia.in_valid = 1'b0; ia.out_ready = 1'b1;
    check("bp_count", 32'(got_a.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_a.size()) check("bp_order", got_a[i], bp_want[i]);
    end

    // Asynchronous reset with two samples in flight.
    ia.out_ready = 1'b0;
    @(posedge clk); #1; ia.in_valid = 1'b1; ia.in_fixed = 16'h0020;
    @(posedge clk); #1; ia.in_fixed = 16'h0030;
    @(posedge clk); #1; ia.in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_out_valid", 32'(ia.out_valid), 32'd1);
    #2; rst = 1'b1; #1;
    check("async_rst_out_valid",  32'(ia.out_valid), 32'd0);
    check("async_rst_out_single", ia.out_single,     32'h0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; ia.out_ready = 1'b1;
    base = outs_a;
    dir_a(16'h0010, 32'h3F80_0000, "post_rst");
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_out_count", 32'(outs_a - base), 32'd1);

    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          @(posedge clk); #1;
          ia.in_valid  = ($urandom_range(0, 3) != 0);
          ia.in_fixed  = 16'(pick(16));
          ia.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 10000; i++) begin
          @(posedge clk); #1;
          ib.in_valid  = ($urandom_range(0, 3) != 0);
          ib.in_fixed  = pick(32);
          ib.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ia.in_valid = 1'b0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("a_drain_empty", 32'(exp_a.size()), 32'd0);
    check("b_drain_empty", 32'(exp_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
